// File: rtl/usb_iap2_ep_engine_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : usb_iap2_ep_engine_pkg
// Purpose  : Shared constants and IN-FSM state encoding for the endpoint engine
// Revision : 1.0 - initial release
// ============================================================================
package usb_iap2_ep_engine_pkg;

    localparam logic [3:0] EP_IAP2         = 4'd2;
    localparam int         MAX_PKT_DEFAULT = 64;

    localparam int ST_W = 3;
    typedef logic [ST_W-1:0] in_state_t;

    localparam in_state_t ST_IDLE     = 3'd0;
    localparam in_state_t ST_FILL     = 3'd1;
    localparam in_state_t ST_READY    = 3'd2;
    localparam in_state_t ST_SEND     = 3'd3;
    localparam in_state_t ST_WAIT_ACK = 3'd4;
    localparam in_state_t ST_ZLP      = 3'd5;

endpackage
`default_nettype wire

// File: rtl/usb_iap2_ep_engine_pkt_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : usb_pkt_buf
// Purpose  : One-packet byte store, synchronous write / asynchronous read
// Revision : 1.0 - initial release
// ============================================================================
module usb_pkt_buf
    import usb_iap2_ep_engine_pkg::*;
#(
    parameter int DEPTH = MAX_PKT_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_usb_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_usb_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/usb_iap2_ep_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : usb_iap2_ep_engine
// Purpose  : Bulk IN/OUT endpoint engine between the USB SIE and the bridge.
//            Optional zero-length-packet support: USB_IAP2_ZLP_EN
// Revision : 1.0 - initial release
// ============================================================================
module usb_iap2_ep_engine
    import usb_iap2_ep_engine_pkg::*;
#(
    parameter logic [3:0] EP_NUM  = EP_IAP2,
    parameter int         MAX_PKT = MAX_PKT_DEFAULT,
    parameter int         LEN_W   = 12
) (
    input  logic             i_usb_clk,
    input  logic             i_usb_rst_n,
    input  logic             i_txcork,
    input  logic [LEN_W-1:0] i_txdat_len,
    input  logic [7:0]       i_txdat,
    output logic             o_txpop,
    output logic             o_txact,
    output logic             o_rxact,
    output logic             o_rxval,
    output logic [7:0]       o_rxdat,
    output logic [3:0]       o_endpt_sel,
    input  logic             i_rxrdy,
    input  logic             i_sie_bus_rst,
    input  logic [3:0]       i_sie_ep,
    input  logic             i_sie_in_req,
    input  logic             i_sie_out_req,
    output logic             o_sie_tx_valid,
    output logic [7:0]       o_sie_tx_data,
    output logic             o_sie_tx_last,
    output logic             o_sie_tx_zlp,
    input  logic             i_sie_tx_ready,
    input  logic             i_sie_ack,
    input  logic             i_sie_timeout,
    input  logic             i_sie_rx_valid,
    input  logic [7:0]       i_sie_rx_data,
    input  logic             i_sie_rx_last,
    output logic             o_sie_nak,
    output logic             o_sie_ack
);

    localparam int c_aw = $clog2(MAX_PKT);
    localparam int c_cw = $clog2(MAX_PKT + 1);

    in_state_t        r_state;
    in_state_t        w_state_nxt;
    logic             r_cork_q;
    logic [LEN_W-1:0] r_remaining;
    logic [c_cw-1:0]  r_fill_cnt;
    logic [c_cw-1:0]  r_send_cnt;
    logic [c_cw-1:0]  w_pkt_len;
    logic             r_in_nak;
    logic             r_out_nak;
    logic             r_out_ack;
    logic             r_rx_act;
    logic             r_rxval;
    logic [7:0]       r_rxdat;
    logic [7:0]       w_buf_rdata;
    logic             w_arm;
    logic             w_len_zero;
    logic             w_in_tok;
    logic             w_out_tok;
    logic             w_pop;
    logic             w_beat;
    logic             w_last;
    logic             w_more;

    assign w_arm      = r_cork_q && !i_txcork;
    assign w_len_zero = (i_txdat_len == '0);
    assign w_in_tok   = i_sie_in_req  && (i_sie_ep == EP_NUM);
    assign w_out_tok  = i_sie_out_req && (i_sie_ep == EP_NUM);
    assign w_pkt_len  = (r_remaining > LEN_W'(MAX_PKT)) ? c_cw'(MAX_PKT) : c_cw'(r_remaining);
    assign w_pop      = (r_state == ST_FILL) && !i_txcork && (r_fill_cnt < w_pkt_len);
    assign w_beat     = (r_state == ST_SEND) && i_sie_tx_ready;
    assign w_last     = (r_send_cnt == w_pkt_len - c_cw'(1));
    assign w_more     = (r_remaining > LEN_W'(w_pkt_len));

    usb_pkt_buf #(
        .DEPTH (MAX_PKT),
        .AW    (c_aw)
    ) u_pkt_buf (
        .i_usb_clk (i_usb_clk),
        .i_we      (w_pop),
        .i_waddr   (r_fill_cnt[c_aw-1:0]),
        .i_wdata   (i_txdat),
        .i_raddr   (r_send_cnt[c_aw-1:0]),
        .o_rdata   (w_buf_rdata)
    );

    always_ff @(posedge i_usb_clk or negedge i_usb_rst_n) begin
        if (!i_usb_rst_n) begin
            r_state <= ST_IDLE;
        end else if (i_sie_bus_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arm) begin
`ifdef USB_IAP2_ZLP_EN
                    w_state_nxt = w_len_zero ? ST_ZLP : ST_FILL;
`else
                    if (!w_len_zero) w_state_nxt = ST_FILL;
`endif
                end
            end
            ST_FILL:  if (r_fill_cnt == w_pkt_len) w_state_nxt = ST_READY;
            ST_READY: if (w_in_tok) w_state_nxt = ST_SEND;
            ST_SEND:  if (w_beat && w_last) w_state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                // ACK takes priority over a simultaneous timeout
                if (i_sie_ack) begin
                    if (w_more) begin
                        w_state_nxt = ST_FILL;
`ifdef USB_IAP2_ZLP_EN
                    end else if (w_pkt_len == c_cw'(MAX_PKT)) begin
                        w_state_nxt = ST_ZLP;
`endif
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (i_sie_timeout) begin
`ifdef USB_IAP2_ZLP_EN
                    w_state_nxt = (w_pkt_len == '0) ? ST_ZLP : ST_READY;
`else
                    w_state_nxt = ST_READY;
`endif
                end
            end
`ifdef USB_IAP2_ZLP_EN
            ST_ZLP:   if (w_in_tok) w_state_nxt = ST_WAIT_ACK;
`endif
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_txact        = (r_state != ST_IDLE);
        o_txpop        = w_pop;
        o_sie_tx_valid = (r_state == ST_SEND);
        o_sie_tx_last  = (r_state == ST_SEND) && w_last;
        o_sie_tx_data  = (r_state == ST_SEND) ? w_buf_rdata : 8'h00;
    end

    always_ff @(posedge i_usb_clk or negedge i_usb_rst_n) begin
        if (!i_usb_rst_n) begin
            r_cork_q    <= 1'b0;
            r_remaining <= '0;
            r_fill_cnt  <= '0;
            r_send_cnt  <= '0;
            r_in_nak    <= 1'b0;
        end else if (i_sie_bus_rst) begin
            r_cork_q    <= 1'b0;
            r_remaining <= '0;
            r_fill_cnt  <= '0;
            r_send_cnt  <= '0;
            r_in_nak    <= 1'b0;
        end else begin
            r_cork_q <= i_txcork;
            if ((r_state == ST_IDLE) && w_arm) begin
                r_remaining <= i_txdat_len;
            end else if ((r_state == ST_WAIT_ACK) && i_sie_ack) begin
                r_remaining <= w_more ? (r_remaining - LEN_W'(w_pkt_len)) : '0;
            end
            if ((w_state_nxt == ST_FILL) && (r_state != ST_FILL)) begin
                r_fill_cnt <= '0;
            end else if (w_pop) begin
                r_fill_cnt <= r_fill_cnt + c_cw'(1);
            end
            if ((r_state == ST_READY) && w_in_tok) begin
                r_send_cnt <= '0;
            end else if (w_beat && !w_last) begin
                r_send_cnt <= r_send_cnt + c_cw'(1);
            end
            r_in_nak <= w_in_tok &&
                        (r_state inside {ST_IDLE, ST_FILL, ST_SEND, ST_WAIT_ACK});
        end
    end

`ifdef USB_IAP2_ZLP_EN
    logic r_zlp;

    always_ff @(posedge i_usb_clk or negedge i_usb_rst_n) begin
        if (!i_usb_rst_n) begin
            r_zlp <= 1'b0;
        end else if (i_sie_bus_rst) begin
            r_zlp <= 1'b0;
        end else begin
            r_zlp <= (r_state == ST_ZLP) && w_in_tok;
        end
    end

    assign o_sie_tx_zlp = r_zlp;
`else
    assign o_sie_tx_zlp = 1'b0;
`endif

    // OUT path runs independently of the IN state machine
    always_ff @(posedge i_usb_clk or negedge i_usb_rst_n) begin
        if (!i_usb_rst_n) begin
            r_rx_act  <= 1'b0;
            r_rxval   <= 1'b0;
            r_rxdat   <= 8'h00;
            r_out_nak <= 1'b0;
            r_out_ack <= 1'b0;
        end else if (i_sie_bus_rst) begin
            r_rx_act  <= 1'b0;
            r_rxval   <= 1'b0;
            r_rxdat   <= 8'h00;
            r_out_nak <= 1'b0;
            r_out_ack <= 1'b0;
        end else begin
            r_out_nak <= w_out_tok && !r_rx_act && !i_rxrdy;
            r_rxval   <= r_rx_act && i_sie_rx_valid;
            r_out_ack <= r_rx_act && i_sie_rx_valid && i_sie_rx_last;
            if (r_rx_act && i_sie_rx_valid) begin
                r_rxdat <= i_sie_rx_data;
            end
            if (w_out_tok && !r_rx_act && i_rxrdy) begin
                r_rx_act <= 1'b1;
            end else if (i_sie_rx_valid && i_sie_rx_last) begin
                r_rx_act <= 1'b0;
            end
        end
    end

    assign o_rxact     = r_rx_act;
    assign o_rxval     = r_rxval;
    assign o_rxdat     = r_rxdat;
    assign o_sie_nak   = r_in_nak | r_out_nak;
    assign o_sie_ack   = r_out_ack;
    assign o_endpt_sel = EP_NUM;

endmodule
`default_nettype wire

// File: tb/tb_usb_iap2_ep_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_usb_iap2_ep_engine
// Purpose  : Self-checking bench: table-driven and randomized IN/OUT traffic
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_iap2_ep_engine;

    localparam int         c_max = 64;
    localparam logic [3:0] c_ep  = 4'd2;
`ifdef USB_IAP2_ZLP_EN
    localparam bit c_zlp = 1'b1;
`else
    localparam bit c_zlp = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        txcork, rxrdy, bus_rst, in_req, out_req, tx_ready, sie_ack_in, timeout;
    logic        rx_valid, rx_last;
    logic [11:0] txdat_len;
    logic [7:0]  txdat, rx_data;
    logic [3:0]  sie_ep, endpt_sel;
    logic        txpop, txact, rxact, rxval, tx_valid, tx_last, tx_zlp, sie_nak, sie_ack;
    logic [7:0]  rxdat, tx_data;

    int errors = 0;
    int checks = 0;
    bit wiggle_en = 1'b0;

    // Bridge model: show-ahead byte source
    logic [7:0] src_mem [8192];
    int src_idx = 0;
    int pop_cnt = 0;
    int stray_pops = 0;

    assign txdat = src_mem[src_idx[12:0]];

    always @(posedge clk) begin
        if (txpop) begin
            src_idx <= src_idx + 1;
            pop_cnt <= pop_cnt + 1;
            if (txcork) stray_pops <= stray_pops + 1;
        end
    end

    always #5 clk = ~clk;

    usb_iap2_ep_engine dut (
        .i_usb_clk      (clk),
        .i_usb_rst_n    (rst_n),
        .i_txcork       (txcork),
        .i_txdat_len    (txdat_len),
        .i_txdat        (txdat),
        .o_txpop        (txpop),
        .o_txact        (txact),
        .o_rxact        (rxact),
        .o_rxval        (rxval),
        .o_rxdat        (rxdat),
        .o_endpt_sel    (endpt_sel),
        .i_rxrdy        (rxrdy),
        .i_sie_bus_rst  (bus_rst),
        .i_sie_ep       (sie_ep),
        .i_sie_in_req   (in_req),
        .i_sie_out_req  (out_req),
        .o_sie_tx_valid (tx_valid),
        .o_sie_tx_data  (tx_data),
        .o_sie_tx_last  (tx_last),
        .o_sie_tx_zlp   (tx_zlp),
        .i_sie_tx_ready (tx_ready),
        .i_sie_ack      (sie_ack_in),
        .i_sie_timeout  (timeout),
        .i_sie_rx_valid (rx_valid),
        .i_sie_rx_data  (rx_data),
        .i_sie_rx_last  (rx_last),
        .o_sie_nak      (sie_nak),
        .o_sie_ack      (sie_ack)
    );

    typedef struct {
        int len;
        int to_pkt;
        int exp_pkts;
        int exp_last;
    } in_vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] src_at(input int i);
        return src_mem[i[12:0]];
    endfunction

    // Reference model: transfer split into full packets plus a short tail
    function automatic int model_pkts(input int len);
        return (len + c_max - 1) / c_max;
    endfunction

    function automatic int model_last(input int len);
        return len - (model_pkts(len) - 1) * c_max;
    endfunction

    function automatic bit model_zlp(input int len);
        return c_zlp && (len % c_max == 0);
    endfunction

    // Host issues IN tokens, backing off on NAK
    task automatic in_token(output bit accepted, output bit zlp_seen);
        accepted = 1'b0;
        zlp_seen = 1'b0;
        for (int t = 0; t < 200 && !accepted; t++) begin
            sie_ep = c_ep;
            in_req = 1'b1;
            step(1);
            in_req = 1'b0;
            if (sie_nak) begin
                int w = $urandom_range(2, 6);
                for (int k = 0; k < w; k++) begin
                    if (wiggle_en) txcork = ($urandom_range(0, 3) == 0);
                    step(1);
                end
                if (wiggle_en) txcork = 1'b0;
            end else begin
                accepted = 1'b1;
                zlp_seen = tx_zlp;
            end
        end
    endtask

    task automatic recv_pkt(input int start, input int exp_len, input string tag);
        int beats = 0;
        int last_at = -1;
        int bad = 0;
        bit done = 1'b0;
        bit v, l, rdy;
        logic [7:0] d;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            rdy = ($urandom_range(0, 3) != 0);
            tx_ready = rdy;
            v = tx_valid;
            d = tx_data;
            l = tx_last;
            step(1);
            if (v && rdy) begin
                if (d !== src_at(start + beats)) bad++;
                if (l) begin
                    last_at = beats;
                    done = 1'b1;
                end
                beats++;
            end
        end
        tx_ready = 1'b0;
        check({tag, " beats"}, beats, exp_len);
        check({tag, " last_pos"}, last_at, exp_len - 1);
        check({tag, " data_errs"}, bad, 0);
    endtask

    task automatic in_transfer(input int len, input int to_pkt, input int np,
                               input int last_len, input string tag);
        int start, base, sz;
        bit acc, zs;
        start = src_idx;
        base = pop_cnt;
        txdat_len = 12'(len);
        txcork = 1'b0;
        step(1);
        check({tag, " txact_armed"}, int'(txact), 1);
        wiggle_en = 1'b1;
        for (int k = 0; k < np; k++) begin
            sz = (k == np - 1) ? last_len : c_max;
            in_token(acc, zs);
            check({tag, " in_accept"}, int'(acc), 1);
            if (!acc) break;
            recv_pkt(start + k * c_max, sz, tag);
            if (k == to_pkt) begin
                timeout = 1'b1;
                step(1);
                timeout = 1'b0;
                in_token(acc, zs);
                recv_pkt(start + k * c_max, sz, {tag, " retx"});
                check({tag, " retx_pops"}, pop_cnt - base, k * c_max + sz);
            end
            sie_ack_in = 1'b1;
            timeout = ($urandom_range(0, 3) == 0);
            step(1);
            sie_ack_in = 1'b0;
            timeout = 1'b0;
        end
        if (model_zlp(len)) begin
            in_token(acc, zs);
            check({tag, " zlp"}, int'(zs), 1);
            sie_ack_in = 1'b1;
            step(1);
            sie_ack_in = 1'b0;
        end
        wiggle_en = 1'b0;
        check({tag, " txact_done"}, int'(txact), 0);
        check({tag, " pops"}, pop_cnt - base, len);
        txcork = 1'b1;
        step(2);
    endtask

    task automatic out_packet(input int n, input bit rdy, input logic [7:0] first,
                              input bit rnd, input string tag);
        int vals = 0, derr = 0, acks = 0, naks = 0;
        logic [7:0] exp_q[$];
        logic [7:0] d;
        sie_ep = c_ep;
        out_req = 1'b1;
        rxrdy = rdy;
        step(1);
        out_req = 1'b0;
        check({tag, " rxact_rise"}, int'(rxact), int'(rdy));
        naks += int'(sie_nak);
        for (int i = 0; i < n; i++) begin
            d = rnd ? 8'($urandom) : first + 8'(i);
            if (rdy) exp_q.push_back(d);
            rx_valid = 1'b1;
            rx_data = d;
            rx_last = (i == n - 1);
            step(1);
            if (rxval) begin
                vals++;
                if (exp_q.size() == 0) derr++;
                else if (rxdat !== exp_q.pop_front()) derr++;
            end
            acks += int'(sie_ack);
            naks += int'(sie_nak);
        end
        rx_valid = 1'b0;
        rx_last = 1'b0;
        step(1);
        vals += int'(rxval);
        acks += int'(sie_ack);
        naks += int'(sie_nak);
        check({tag, " rxval_count"}, vals, rdy ? n : 0);
        check({tag, " rxdat_errs"}, derr, 0);
        check({tag, " out_acks"}, acks, rdy ? 1 : 0);
        check({tag, " out_naks"}, naks, rdy ? 0 : 1);
        check({tag, " rxact_end"}, int'(rxact), 0);
        rxrdy = 1'b0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        in_vec_t vecs[6];
        int len, np, to;
        bit acc, zs;

        vecs = '{'{10, -1, 1, 10}, '{150, -1, 3, 22}, '{64, 0, 1, 64},
                 '{128, -1, 2, 64}, '{65, 1, 2, 1}, '{1, -1, 1, 1}};

        for (int i = 0; i < 8192; i++) src_mem[i] = 8'($urandom);
        txcork = 1'b1; rxrdy = 1'b0; bus_rst = 1'b0; in_req = 1'b0; out_req = 1'b0;
        tx_ready = 1'b0; sie_ack_in = 1'b0; timeout = 1'b0; rx_valid = 1'b0;
        rx_last = 1'b0; txdat_len = '0; rx_data = '0; sie_ep = '0;

        step(3);
        check("reset outputs",
              int'({txpop, txact, rxact, rxval, rxdat, tx_valid, tx_data, tx_last,
                    tx_zlp, sie_nak, sie_ack}), 0);
        check("endpt_sel", int'(endpt_sel), int'(c_ep));
        rst_n = 1'b1;
        step(3);

        // IN token while idle is NAKed; other endpoints are ignored
        sie_ep = c_ep; in_req = 1'b1; step(1); in_req = 1'b0;
        check("idle nak", int'(sie_nak), 1);
        step(1);
        check("nak one cycle", int'(sie_nak), 0);
        sie_ep = 4'd3; in_req = 1'b1; step(1); in_req = 1'b0;
        check("ep3 ignored", int'({sie_nak, tx_valid}), 0);
        step(1);

        for (int i = 0; i < 6; i++) begin
            in_transfer(vecs[i].len, vecs[i].to_pkt, vecs[i].exp_pkts,
                        vecs[i].exp_last, $sformatf("vec%0d", i));
        end

        out_packet(5, 1'b1, 8'hA1, 1'b0, "out_rdy");
        out_packet(5, 1'b0, 8'hA1, 1'b0, "out_busy");

        // Zero-length arm
        txdat_len = '0; txcork = 1'b0; step(2);
`ifdef USB_IAP2_ZLP_EN
        in_token(acc, zs);
        check("len0 zlp", int'(zs), 1);
        sie_ack_in = 1'b1; step(1); sie_ack_in = 1'b0;
        check("len0 txact", int'(txact), 0);
`else
        check("len0 txact", int'(txact), 0);
        sie_ep = c_ep; in_req = 1'b1; step(1); in_req = 1'b0;
        check("len0 nak", int'(sie_nak), 1);
`endif
        txcork = 1'b1; step(2);

        // Bus reset in the middle of a fill
        txdat_len = 12'd40; txcork = 1'b0; step(10);
        check("busrst pre txact", int'(txact), 1);
        bus_rst = 1'b1; step(1); bus_rst = 1'b0;
        check("busrst txact", int'({txact, txpop}), 0);
        txcork = 1'b1; step(2);
        sie_ep = c_ep; in_req = 1'b1; step(1); in_req = 1'b0;
        check("busrst idle nak", int'(sie_nak), 1);
        step(2);

        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 200);
            np = model_pkts(len);
            to = int'($urandom_range(0, np)) - 1;
            in_transfer(len, to, np, model_last(len), $sformatf("rnd%0d", r));
            out_packet($urandom_range(1, 16), $urandom_range(0, 1) == 1, 8'h00, 1'b1,
                       $sformatf("rndout%0d", r));
        end

        check("stray pops", stray_pops, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
